mux_sw_sequencer: RTL and testbench

Sequential controller for the channel-to-capacitor thermometer mux. It walks one switch decision per clock across the CAPACITOR_NUM capacitor slots. On each step it either steers the next unconsumed channel bit into the capacitor word or fills the slot with 1, exactly as one fundamental combinational stage does. It sits between the channel-data source and the capacitor-array driver, latching a request, sequencing all stages, and presenting a held result with a done pulse.

---
 rtl/mux_sw_sequencer.sv | 123 ++++++++++++
 tb/tb_mux_sw_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sw_sequencer.sv
// Sequential channel-to-capacitor thermometer mux: one switch decision per clock,
// steering the next unconsumed channel bit into a capacitor slot or filling it with 1.
module mux_sw_sequencer #(
  parameter int CHANNEL_NUM   = 128,
  parameter int CAPACITOR_NUM = 70,
  parameter int CNT_W         = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CHANNEL_NUM-1:0]   din,
  input  logic [CAPACITOR_NUM-1:0] sw_mask,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [CAPACITOR_NUM-1:0] dout,
  output logic                     dout_valid,
  output logic [CHANNEL_NUM-1:0]   din_rem,
  output logic [CNT_W-1:0]         used_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CAPACITOR_NUM - 1);

  state_t                   r_state;
  logic [CHANNEL_NUM-1:0]   r_din;
  logic [CAPACITOR_NUM-1:0] r_mask;
  logic [CAPACITOR_NUM-1:0] r_cap;
  logic [CNT_W-1:0]         r_step;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_busy;
  logic                     r_done;
  logic [CAPACITOR_NUM-1:0] r_dout;
  logic                     r_dout_valid;
  logic [CHANNEL_NUM-1:0]   r_din_rem;
  logic [CNT_W-1:0]         r_used_cnt;

  // The mask is shifted right every step, so bit 0 is always the current step's enable.
  logic                     w_sel;
  logic                     w_last;
  logic [CAPACITOR_NUM-1:0] w_cap_next;
  logic [CHANNEL_NUM-1:0]   w_din_next;
  logic [CNT_W-1:0]         w_cnt_next;

  assign w_sel      = r_mask[0];
  assign w_last     = (r_step == LAST_STEP);
  assign w_cap_next = {(w_sel ? r_din[0] : 1'b1), r_cap[CAPACITOR_NUM-1:1]};
  assign w_din_next = w_sel ? {1'b1, r_din[CHANNEL_NUM-1:1]} : r_din;
  assign w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, w_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_din        <= '1;
      r_mask       <= '0;
      r_cap        <= '1;
      r_step       <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dout       <= '1;
      r_dout_valid <= 1'b0;
      r_din_rem    <= '1;
      r_used_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_din        <= din;
            r_mask       <= sw_mask;
            r_cap        <= '1;
            r_step       <= '0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            // Abort beats the final step: results from the previous run are kept.
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_cap  <= w_cap_next;
            r_din  <= w_din_next;
            r_cnt  <= w_cnt_next;
            r_mask <= r_mask >> 1;
            if (w_last) begin
              r_dout       <= w_cap_next;
              r_din_rem    <= w_din_next;
              r_used_cnt   <= w_cnt_next;
              r_dout_valid <= 1'b1;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign din_rem    = r_din_rem;
  assign used_cnt   = r_used_cnt;

endmodule

// File: tb/tb_mux_sw_sequencer.sv
// Directed + random bench for mux_sw_sequencer; expected results come from a
// closed-form model pushed to a scoreboard queue at start and popped at done.
module tb_mux_sw_sequencer;

  localparam int CH   = 128;
  localparam int CAP  = 70;
  localparam int CW   = 7;
  localparam int LAT  = CAP;   // edges from the accepting edge to the done edge

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CH-1:0]   din;
  logic [CAP-1:0]  sw_mask;
  logic            abort;
  logic            busy;
  logic            done;
  logic [CAP-1:0]  dout;
  logic            dout_valid;
  logic [CH-1:0]   din_rem;
  logic [CW-1:0]   used_cnt;

  mux_sw_sequencer #(.CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .sw_mask(sw_mask), .abort(abort),
    .busy(busy), .done(done), .dout(dout), .dout_valid(dout_valid),
    .din_rem(din_rem), .used_cnt(used_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CAP-1:0] d;
    logic [CH-1:0]  r;
    logic [CW-1:0]  u;
  } exp_t;

  exp_t sbq[$];
  exp_t last_e;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model(input logic [CH-1:0] d, input logic [CAP-1:0] m);
    exp_t e;
    int   idx;
    idx = 0;
    for (int k = 0; k < CAP; k++) begin
      if (m[k]) begin
        e.d[k] = d[idx];
        idx++;
      end else begin
        e.d[k] = 1'b1;
      end
    end
    for (int i = 0; i < CH; i++) e.r[i] = (i + idx < CH) ? d[i + idx] : 1'b1;
    e.u = CW'(idx);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_busy"}, CH'(busy), CH'(0));
    chk({tag, "_done"}, CH'(done), CH'(0));
    chk({tag, "_valid"}, CH'(dout_valid), CH'(0));
    chk({tag, "_dout"}, CH'(dout), CH'(last_e.d));
    chk({tag, "_rem"}, din_rem, last_e.r);
    chk({tag, "_used"}, CH'(used_cnt), CH'(last_e.u));
  endtask

  // Full run; returns at the done cycle so a following run starts back-to-back.
  task automatic run(input logic [CH-1:0] d, input logic [CAP-1:0] m, input bit inj,
                     input string tag);
    exp_t e;
    int   edges;
    din = d; sw_mask = m; start = 1'b1;
    sbq.push_back(model(d, m));
    tick();
    start = 1'b0;
    chk({tag, "_busy_e0"}, CH'(busy), CH'(1));
    chk({tag, "_done_e0"}, CH'(done), CH'(0));
    chk({tag, "_valid_e0"}, CH'(dout_valid), CH'(0));
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      tick();
      edges++;
      if (inj && edges == 10) begin
        start = 1'b1; din = ~d; sw_mask = ~m;
      end else if (inj && edges == 11) begin
        start = 1'b0;
      end
    end
    chk({tag, "_latency"}, CH'(edges), CH'(LAT));
    e = sbq.pop_front();
    chk({tag, "_busy"}, CH'(busy), CH'(0));
    chk({tag, "_valid"}, CH'(dout_valid), CH'(1));
    chk({tag, "_dout"}, CH'(dout), CH'(e.d));
    chk({tag, "_rem"}, din_rem, e.r);
    chk({tag, "_used"}, CH'(used_cnt), CH'(e.u));
    last_e = e;
  endtask

  task automatic run_abort(input logic [CH-1:0] d, input logic [CAP-1:0] m, input int at,
                           input string tag);
    int done_seen;
    din = d; sw_mask = m; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_held(tag);
    done_seen = 0;
    repeat (5) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    chk({tag, "_nodone"}, CH'(done_seen), CH'(0));
    chk({tag, "_idle"}, CH'(busy), CH'(0));
  endtask

  initial begin
    logic [CH-1:0]  c_din;
    logic [CH-1:0]  r_d;
    logic [95:0]    r_w;
    logic [95:0]    r_w2;
    logic [CAP-1:0] m;
    int             done_seen;

    rst = 1'b1; start = 1'b0; abort = 1'b0; din = '0; sw_mask = '0;
    last_e.d = '1; last_e.r = '1; last_e.u = '0;
    tick();
    chk_held("reset");
    rst = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_held("idle_abort");

    // All switches on
    c_din = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    run(c_din, '1, 1'b0, "allon");
    chk("allon_dout_direct", CH'(dout), CH'(c_din[CAP-1:0]));
    chk("allon_rem_direct", din_rem, {{CAP{1'b1}}, c_din[CH-1:CAP]});
    chk("allon_used_direct", CH'(used_cnt), CH'(70));
    tick();
    chk("done_one_cycle", CH'(done), CH'(0));

    // All switches off
    r_d = {$urandom, $urandom, $urandom, $urandom};
    run(r_d, '0, 1'b0, "alloff");
    chk("alloff_dout_direct", CH'(dout), {CH{1'b1}} >> (CH - CAP));
    chk("alloff_rem_direct", din_rem, r_d);

    // Sparse mask, back-to-back with the previous run
    m = '0; m[0] = 1'b1; m[5] = 1'b1; m[69] = 1'b1;
    run(128'h5, m, 1'b0, "sparse");
    chk("sparse_bit5", CH'(dout[5]), CH'(0));
    chk("sparse_bit69", CH'(dout[69]), CH'(1));
    chk("sparse_bit0", CH'(dout[0]), CH'(1));
    chk("sparse_used", CH'(used_cnt), CH'(3));
    chk("sparse_rem_top", CH'(din_rem[CH-1:CH-3]), CH'(7));

    // Aborts mid-run and on the final step
    tick();
    run_abort(~c_din, '1, 40, "abort40");
    run_abort(c_din, '1, CAP - 1, "abort_last");

    // Reset in the middle of a run
    din = c_din; sw_mask = '1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    #2;
    last_e.d = '1; last_e.r = '1; last_e.u = '0;
    chk_held("rst_mid");
    tick();
    rst = 1'b0;
    done_seen = 0;
    repeat (80) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    chk("rst_mid_nodone", CH'(done_seen), CH'(0));
    run(c_din, 70'h2A_AAAA_AAAA_AAAA_AAAA, 1'b0, "after_rst");

    // Start pulsed mid-run must be ignored
    run(~c_din, 70'h15_5555_5555_5555_5555, 1'b1, "midstart");
    tick();
    chk("midstart_not_queued", CH'(busy), CH'(0));

    // Random runs against the closed-form model
    for (int n = 0; n < 500; n++) begin
      r_d  = {$urandom, $urandom, $urandom, $urandom};
      r_w  = {$urandom, $urandom, $urandom};
      r_w2 = {$urandom, $urandom, $urandom};
      case (n % 4)
        0: r_w = r_w & r_w2;
        1: r_w = r_w | r_w2;
        default: ;
      endcase
      m = r_w[CAP-1:0];
      run(r_d, m, (n % 50) == 7, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
